// File: rtl/count_mode_sequencer.sv
// Mode sequencer for the two-digit button-demo counter: arbitrates clear, mode advance,
// manual steps and auto ticks into one registered count/BCD update per clock.
module count_mode_sequencer #(
  parameter int unsigned MAX_COUNT = 99,
  parameter int unsigned TICK_DIV  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_pulse,
  input  logic       dec_pulse,
  input  logic       mode_pulse,
  input  logic       clr_pulse,
  output logic [6:0] count,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [1:0] mode,
  output logic       step,
  output logic       wrap
);

  localparam int unsigned     DivW    = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
  localparam logic [6:0]      MaxVal  = 7'(MAX_COUNT);

  typedef enum logic [1:0] {
    StManual   = 2'd0,
    StAutoUp   = 2'd1,
    StAutoDown = 2'd2,
    StPause    = 2'd3
  } mode_e;

  mode_e           mode_q, mode_d;
  logic [6:0]      count_q, count_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic [DivW-1:0] div_q, div_d;
  logic            step_q, step_d;
  logic            wrap_q, wrap_d;
  logic            go_up, go_dn;

  always_comb begin
    mode_d  = mode_q;
    count_d = count_q;
    div_d   = '0;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    go_up   = 1'b0;
    go_dn   = 1'b0;

    if (clr_pulse) begin
      count_d = '0;
    end else if (mode_pulse) begin
      unique case (mode_q)
        StManual:   mode_d = StAutoUp;
        StAutoUp:   mode_d = StAutoDown;
        StAutoDown: mode_d = StPause;
        StPause:    mode_d = StManual;
        default:    mode_d = StManual;
      endcase
    end else begin
      unique case (mode_q)
        StManual: begin
          // Simultaneous inc and dec cancel out.
          go_up = inc_pulse & ~dec_pulse;
          go_dn = dec_pulse & ~inc_pulse;
        end
        StAutoUp, StAutoDown: begin
          if (div_q == DivLast) begin
            go_up = (mode_q == StAutoUp);
            go_dn = (mode_q == StAutoDown);
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (go_up) begin
      step_d = 1'b1;
      if (count_q == MaxVal) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 7'd1;
      end
    end else if (go_dn) begin
      step_d = 1'b1;
      if (count_q == '0) begin
        count_d = MaxVal;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q - 7'd1;
      end
    end

    // Digits derive from the next count so they land on the same edge as count.
    tens_d = 4'(count_d / 7'd10);
    ones_d = 4'(count_d % 7'd10);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= StManual;
      count_q <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      div_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      div_q   <= div_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count    = count_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
  assign mode     = mode_q;
  assign step     = step_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_count_mode_sequencer.sv
// Bench for count_mode_sequencer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_count_mode_sequencer;

  localparam int MaxCount = 12;
  localparam int TickDiv  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc_pulse, dec_pulse, mode_pulse, clr_pulse;
  logic [6:0] count;
  logic [3:0] bcd_tens, bcd_ones;
  logic [1:0] mode;
  logic       step, wrap;

  count_mode_sequencer #(
    .MAX_COUNT (MaxCount),
    .TICK_DIV  (TickDiv)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .mode_pulse (mode_pulse),
    .clr_pulse  (clr_pulse),
    .count      (count),
    .bcd_tens   (bcd_tens),
    .bcd_ones   (bcd_ones),
    .mode       (mode),
    .step       (step),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: count as an integer modulo MaxCount+1, cycles elapsed since the
  // auto timer was last restarted, and the expected pulses of the latest edge.
  int m_count, m_mode, m_elapsed, m_step, m_wrap;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_count = 0; m_mode = 0; m_elapsed = 0; m_step = 0; m_wrap = 0;
  endfunction

  function automatic void model_edge(input logic inc, input logic dec, input logic mp,
                                     input logic clr);
    int delta = 0;
    m_step = 0;
    m_wrap = 0;
    if (clr) begin
      m_count = 0;
      m_elapsed = 0;
    end else if (mp) begin
      m_mode = (m_mode + 1) % 4;
      m_elapsed = 0;
    end else if (m_mode == 0) begin
      delta = int'(inc) - int'(dec);
    end else if (m_mode == 1 || m_mode == 2) begin
      m_elapsed++;
      if (m_elapsed == TickDiv) begin
        m_elapsed = 0;
        delta = (m_mode == 1) ? 1 : -1;
      end
    end
    if (delta != 0) begin
      m_step = 1;
      m_wrap = ((delta > 0 && m_count == MaxCount) || (delta < 0 && m_count == 0)) ? 1 : 0;
      m_count = (m_count + delta + MaxCount + 1) % (MaxCount + 1);
    end
  endfunction

  // Every falling edge: DUT outputs must match the model state.
  always @(negedge clk) begin
    check("count", int'(count), m_count);
    check("bcd_tens", int'(bcd_tens), m_count / 10);
    check("bcd_ones", int'(bcd_ones), m_count % 10);
    check("mode", int'(mode), m_mode);
    check("step", int'(step), m_step);
    check("wrap", int'(wrap), m_wrap);
  end

  task automatic cycle(input logic inc, input logic dec, input logic mp, input logic clr);
    inc_pulse = inc; dec_pulse = dec; mode_pulse = mp; clr_pulse = clr;
    @(posedge clk);
    model_edge(inc, dec, mp, clr);
    #1;
    inc_pulse = 1'b0; dec_pulse = 1'b0; mode_pulse = 1'b0; clr_pulse = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("rst_count", int'(count), 0);
    check("rst_tens", int'(bcd_tens), 0);
    check("rst_ones", int'(bcd_ones), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_step", int'(step), 0);
    check("rst_wrap", int'(wrap), 0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    inc_pulse = 1'b0; dec_pulse = 1'b0; mode_pulse = 1'b0; clr_pulse = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_count", int'(count), 0);
    check("init_mode", int'(mode), 0);
    check("init_step", int'(step), 0);
    rst = 1'b1;

    // Three manual increments.
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("inc_count", int'(count), i);
      check("inc_step", int'(step), 1);
      check("inc_wrap", int'(wrap), 0);
    end
    idle(1);
    check("idle_step", int'(step), 0);

    // Decrement at zero wraps to MaxCount.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_count", int'(count), 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("dwrap_count", int'(count), 12);
    check("dwrap_tens", int'(bcd_tens), 1);
    check("dwrap_ones", int'(bcd_ones), 2);
    check("dwrap_step", int'(step), 1);
    check("dwrap_wrap", int'(wrap), 1);
    idle(1);
    check("dwrap_wrap_end", int'(wrap), 0);
    check("dwrap_step_end", int'(step), 0);

    // inc and dec together cancel.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("both_count", int'(count), 5);
    check("both_step", int'(step), 0);

    // AUTO_UP from 11: 12 after 4 cycles, wrap to 0 after 4 more; inc ignored.
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("au_mode", int'(mode), 1);
    check("au_count0", int'(count), 11);
    idle(1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("au_count3", int'(count), 11);
    idle(1);
    check("au_count4", int'(count), 12);
    check("au_step4", int'(step), 1);
    check("au_wrap4", int'(wrap), 0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("au_count7", int'(count), 12);
    idle(1);
    check("au_count8", int'(count), 0);
    check("au_wrap8", int'(wrap), 1);

    // AUTO_DOWN: clr + mode on the tick cycle.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("ad_mode", int'(mode), 2);
    idle(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("ad_clr_count", int'(count), 0);
    check("ad_clr_mode", int'(mode), 2);
    check("ad_clr_step", int'(step), 0);
    idle(3);
    check("ad_count3", int'(count), 0);
    idle(1);
    check("ad_count4", int'(count), 12);
    check("ad_wrap4", int'(wrap), 1);

    // PAUSE freezes count; cycle round to AUTO_UP and run to 7, then reset mid-run.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("pause_mode", int'(mode), 3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    check("pause_count", int'(count), 12);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("manual_mode", int'(mode), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(28);
    check("au7_count", int'(count), 7);
    check("au7_step", int'(step), 1);
    async_reset();

    // Randomized traffic, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        cycle(logic'($urandom_range(0, 99) < 30), logic'($urandom_range(0, 99) < 30),
              logic'($urandom_range(0, 99) < 5), logic'($urandom_range(0, 99) < 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
